// File: rtl/br_flow_join_buffered.sv
// Buffered flow join: each push flow feeds its own Depth-entry FIFO; one pop drains every FIFO head at once.
// Optional macro BR_FLOW_JOIN_SKEW_STALL_CNT_EN adds a saturating skew_stall_count output.
module br_flow_join_buffered #(
    parameter int NumFlows = 2,
    parameter int Width = 8,
    parameter int Depth = 2,
    parameter bit EnableAssertPushValidStability = 1,
    parameter bit EnableAssertFinalNotValid = 1,
    localparam int CW = $clog2(Depth + 1),
    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [NumFlows-1:0]       push_ready,
    input  logic [NumFlows-1:0]       push_valid,
    input  logic [NumFlows*Width-1:0] push_data,
    input  logic                      pop_ready,
    output logic                      pop_valid,
    output logic [NumFlows*Width-1:0] pop_data,
    output logic [NumFlows*CW-1:0]    occupancy
`ifdef BR_FLOW_JOIN_SKEW_STALL_CNT_EN
    ,
    output logic [31:0]               skew_stall_count
`endif
);

    logic                live;
    logic                pop;
    logic [NumFlows-1:0] nonempty;
    logic [NumFlows-1:0] push;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(Depth - 1)) return '0;
        return p + PW'(1);
    endfunction

    // Holds push_ready low while in reset and for the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

    assign pop_valid = &nonempty;
    assign pop       = pop_valid & pop_ready;

    for (genvar i = 0; i < NumFlows; i++) begin : g_flow
        logic [CW-1:0]          count;
        logic [PW-1:0]          wr_ptr;
        logic [PW-1:0]          rd_ptr;
        logic [Depth*Width-1:0] mem;

        assign nonempty[i]                = (count != '0);
        assign push_ready[i]              = live && (count < CW'(Depth));
        assign push[i]                    = push_valid[i] & push_ready[i];
        assign occupancy[i*CW +: CW]      = count;
        assign pop_data[i*Width +: Width] = mem[int'(rd_ptr)*Width +: Width];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[i]) wr_ptr <= ptr_next(wr_ptr);
                if (pop)     rd_ptr <= ptr_next(rd_ptr);
                if (push[i] && !pop)      count <= count + CW'(1);
                else if (!push[i] && pop) count <= count - CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (push[i]) mem[int'(wr_ptr)*Width +: Width] <= push_data[i*Width +: Width];
        end

`ifndef SYNTHESIS
        a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
            !(push[i] && count == CW'(Depth)));
        a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
            !(pop && count == '0));
        a_occ_range: assert property (@(posedge clk) disable iff (!rst_n)
            count <= CW'(Depth));
        if (EnableAssertPushValidStability) begin : g_push_stable
            a_push_stable: assert property (@(posedge clk) disable iff (!rst_n)
                push_valid[i] && !push_ready[i] |=>
                    push_valid[i] && $stable(push_data[i*Width +: Width]));
        end
`endif
    end

`ifdef BR_FLOW_JOIN_SKEW_STALL_CNT_EN
    // Counts cycles where some flow has data but the join waits on a lagging flow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skew_stall_count <= '0;
        end else if (!pop_valid && (|nonempty) && (skew_stall_count != '1)) begin
            skew_stall_count <= skew_stall_count + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_params: assert property (@(posedge clk)
        (NumFlows >= 2) && (Width >= 1) && (Depth >= 1));
    a_pop_stable: assert property (@(posedge clk) disable iff (!rst_n)
        pop_valid && !pop_ready |=> pop_valid && $stable(pop_data));
    if (EnableAssertFinalNotValid) begin : g_final
        final begin
            a_final_idle: assert (!(|push_valid) && !pop_valid);
        end
    end
`endif

endmodule

// File: tb/tb_br_flow_join_buffered.sv
// Bench for br_flow_join_buffered: a Depth=2 and a Depth=1 instance checked against a queue-based model.
`timescale 1ns/1ps
module tb_br_flow_join_buffered;

    localparam int NF = 3;
    localparam int W  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NF-1:0]   pv [2];
    logic [NF*W-1:0] pd [2];
    logic            pr [2];

    logic [NF-1:0]   prdy0, prdy1;
    logic            popv0, popv1;
    logic [NF*W-1:0] popd0, popd1;
    logic [NF*2-1:0] occ0;
    logic [NF*1-1:0] occ1;
`ifdef BR_FLOW_JOIN_SKEW_STALL_CNT_EN
    logic [31:0]     ssc0, ssc1;
`endif

    int total = 0;
    int bad   = 0;

    br_flow_join_buffered #(.NumFlows(NF), .Width(W), .Depth(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .push_ready(prdy0), .push_valid(pv[0]), .push_data(pd[0]),
        .pop_ready(pr[0]), .pop_valid(popv0), .pop_data(popd0), .occupancy(occ0)
`ifdef BR_FLOW_JOIN_SKEW_STALL_CNT_EN
        , .skew_stall_count(ssc0)
`endif
    );

    br_flow_join_buffered #(.NumFlows(NF), .Width(W), .Depth(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .push_ready(prdy1), .push_valid(pv[1]), .push_data(pd[1]),
        .pop_ready(pr[1]), .pop_valid(popv1), .pop_data(popd1), .occupancy(occ1)
`ifdef BR_FLOW_JOIN_SKEW_STALL_CNT_EN
        , .skew_stall_count(ssc1)
`endif
    );

    // Reference model: one queue per (instance, flow); index d*NF+i.
    logic [W-1:0] mq [6][$];
    bit           m_live [2];
    bit           m_acc [6];
    bit           m_pop [2];
    logic [NF-1:0] m_r;
    int unsigned  m_stall;

    function automatic int dep(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic bit m_popv(int d);
        for (int i = 0; i < NF; i++) if (mq[d*NF+i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_any(int d);
        for (int i = 0; i < NF; i++) if (mq[d*NF+i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NF-1:0] m_rdy(int d);
        logic [NF-1:0] r;
        for (int i = 0; i < NF; i++) r[i] = m_live[d] && (mq[d*NF+i].size() < dep(d));
        return r;
    endfunction

    function automatic logic [NF*W-1:0] m_popd(int d);
        logic [NF*W-1:0] r;
        r = '0;
        for (int i = 0; i < NF; i++)
            if (mq[d*NF+i].size() != 0) r[i*W +: W] = mq[d*NF+i][0];
        return r;
    endfunction

    function automatic logic [NF-1:0] o_rdy(int d);
        return (d == 0) ? prdy0 : prdy1;
    endfunction

    function automatic logic o_popv(int d);
        return (d == 0) ? popv0 : popv1;
    endfunction

    function automatic logic [NF*W-1:0] o_popd(int d);
        return (d == 0) ? popd0 : popd1;
    endfunction

    function automatic int o_occ(int d, int i);
        return (d == 0) ? int'(occ0[i*2 +: 2]) : int'(occ1[i]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) m_live[d] = 1'b0;
            for (int q = 0; q < 6; q++) begin
                mq[q].delete();
                m_acc[q] = 1'b0;
            end
            m_stall = 0;
        end else begin
            if (!m_popv(0) && m_any(0) && m_stall != 32'hFFFF_FFFF) m_stall++;
            for (int d = 0; d < 2; d++) begin
                m_pop[d] = m_popv(d) && pr[d];
                m_r = m_rdy(d);
                for (int i = 0; i < NF; i++) begin
                    m_acc[d*NF+i] = pv[d][i] && m_r[i];
                    if (m_pop[d]) void'(mq[d*NF+i].pop_front());
                    if (m_acc[d*NF+i]) mq[d*NF+i].push_back(pd[d][i*W +: W]);
                end
                m_live[d] = 1'b1;
            end
        end
    end

    task automatic test_reset;
        pv[0] = '0; pv[1] = '0; pd[0] = '0; pd[1] = '0; pr[0] = 1'b0; pr[1] = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (prdy0 !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b want=000", prdy0); end
        total++; if (popv0 !== 1'b0) begin bad++; $display("FAIL reset_pop_valid got=%b want=0", popv0); end
        total++; if (occ0 !== '0) begin bad++; $display("FAIL reset_occ got=%h want=0", occ0); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (prdy0 !== 3'b111) begin bad++; $display("FAIL post_reset_ready got=%b want=111", prdy0); end
        total++; if (prdy1 !== 3'b111) begin bad++; $display("FAIL post_reset_ready_d1 got=%b want=111", prdy1); end
        total++; if (occ0 !== '0) begin bad++; $display("FAIL post_reset_occ got=%h want=0", occ0); end
    endtask

    task automatic test_aligned;
        logic [7:0] v;
        pr[0] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            v = 8'(8'h10 + k);
            pv[0] = 3'b111;
            pd[0] = {3{v}};
            @(negedge clk);
            total++;
            if (popv0 !== 1'b1 || popd0 !== {3{v}}) begin
                bad++; $display("FAIL aligned_pop k=%0d got=%b/%h want=1/%h", k, popv0, popd0, {3{v}});
            end
            total++; if (prdy0 !== 3'b111) begin bad++; $display("FAIL aligned_ready k=%0d got=%b want=111", k, prdy0); end
        end
        pv[0] = '0;
        @(negedge clk);
        total++; if (popv0 !== 1'b0 || occ0 !== '0) begin
            bad++; $display("FAIL aligned_drain got=%b/%h want=0/0", popv0, occ0);
        end
    endtask

    task automatic test_skew;
        pr[0] = 1'b1;
        pv[0] = 3'b001; pd[0] = {8'h00, 8'h00, 8'hA1};
        @(negedge clk);
        pd[0] = {8'h00, 8'h00, 8'hA2};
        @(negedge clk);
        pv[0] = '0;
        total++; if (occ0[1:0] !== 2'd2) begin bad++; $display("FAIL skew_occ0 got=%0d want=2", occ0[1:0]); end
        total++; if (prdy0 !== 3'b110) begin bad++; $display("FAIL skew_ready got=%b want=110", prdy0); end
        total++; if (popv0 !== 1'b0) begin bad++; $display("FAIL skew_pop_valid got=%b want=0", popv0); end
        pv[0] = 3'b110; pd[0] = {8'hC1, 8'hB1, 8'h00};
        @(negedge clk);
        pv[0] = '0;
        total++; if (popv0 !== 1'b1 || popd0 !== {8'hC1, 8'hB1, 8'hA1}) begin
            bad++; $display("FAIL skew_join got=%b/%h want=1/c1b1a1", popv0, popd0);
        end
        @(negedge clk);
        total++; if (prdy0 !== 3'b111) begin bad++; $display("FAIL skew_ready_after got=%b want=111", prdy0); end
        total++; if (popv0 !== 1'b0 || occ0 !== 6'b00_00_01) begin
            bad++; $display("FAIL skew_after got=%b/%b want=0/000001", popv0, occ0);
        end
        pv[0] = 3'b110; pd[0] = {8'hC2, 8'hB2, 8'h00};
        @(negedge clk);
        pv[0] = '0;
        total++; if (popd0 !== {8'hC2, 8'hB2, 8'hA2}) begin bad++; $display("FAIL skew_join2 got=%h want=c2b2a2", popd0); end
        @(negedge clk);
        total++; if (occ0 !== '0) begin bad++; $display("FAIL skew_drain got=%b want=0", occ0); end
    endtask

    task automatic test_backpressure;
        pr[0] = 1'b0;
        pv[0] = 3'b111; pd[0] = {3{8'h40}};
        @(negedge clk);
        pd[0] = {3{8'h41}};
        @(negedge clk);
        pv[0] = '0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (popv0 !== 1'b1 || popd0 !== {3{8'h40}} || prdy0 !== 3'b000 || occ0 !== 6'b10_10_10) begin
                bad++; $display("FAIL bp_hold k=%0d got=%b/%h/%b/%b want=1/404040/000/101010",
                                k, popv0, popd0, prdy0, occ0);
            end
            @(negedge clk);
        end
        pr[0] = 1'b1;
        total++; if (popd0 !== {3{8'h40}}) begin bad++; $display("FAIL bp_first got=%h want=404040", popd0); end
        @(negedge clk);
        total++; if (popv0 !== 1'b1 || popd0 !== {3{8'h41}}) begin
            bad++; $display("FAIL bp_second got=%b/%h want=1/414141", popv0, popd0);
        end
        @(negedge clk);
        total++; if (popv0 !== 1'b0 || occ0 !== '0) begin bad++; $display("FAIL bp_drain got=%b/%b want=0/0", popv0, occ0); end
    endtask

    task automatic test_depth1;
        logic [7:0] nxt;
        logic [7:0] expv;
        logic       want;
        int         npop;
        nxt = 8'h60; expv = 8'h60; npop = 0;
        pr[1] = 1'b1;
        pv[1] = 3'b111; pd[1] = {3{nxt}};
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (m_acc[3] && m_acc[4] && m_acc[5]) begin
                nxt = nxt + 8'd1;
                pd[1] = {3{nxt}};
            end
            want = (k % 2) == 1;
            total++; if (popv1 !== want) begin bad++; $display("FAIL d1_pop_valid k=%0d got=%b want=%b", k, popv1, want); end
            if (want) begin
                total++; if (popd1 !== {3{expv}}) begin bad++; $display("FAIL d1_pop_data k=%0d got=%h want=%h", k, popd1, {3{expv}}); end
                expv = expv + 8'd1;
            end
            if (popv1 === 1'b1) npop++;
        end
        total++; if (npop !== 12) begin bad++; $display("FAIL d1_pop_count got=%0d want=12", npop); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (m_acc[3] && m_acc[4] && m_acc[5]) pv[1] = '0;
        end
        total++; if (occ1 !== '0 || popv1 !== 1'b0) begin bad++; $display("FAIL d1_drain got=%b/%b want=0/0", occ1, popv1); end
    endtask

    task automatic test_random;
        logic [NF-1:0] er;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                er = m_rdy(d);
                total++; if (o_rdy(d) !== er) begin bad++; $display("FAIL rnd_ready d=%0d c=%0d got=%b want=%b", d, c, o_rdy(d), er); end
                total++; if (o_popv(d) !== m_popv(d)) begin bad++; $display("FAIL rnd_pop_valid d=%0d c=%0d got=%b want=%b", d, c, o_popv(d), m_popv(d)); end
                if (m_popv(d)) begin
                    total++; if (o_popd(d) !== m_popd(d)) begin bad++; $display("FAIL rnd_pop_data d=%0d c=%0d got=%h want=%h", d, c, o_popd(d), m_popd(d)); end
                end
                for (int i = 0; i < NF; i++) begin
                    total++; if (o_occ(d, i) !== mq[d*NF+i].size()) begin
                        bad++; $display("FAIL rnd_occ d=%0d i=%0d c=%0d got=%0d want=%0d", d, i, c, o_occ(d, i), mq[d*NF+i].size());
                    end
                end
            end
`ifdef BR_FLOW_JOIN_SKEW_STALL_CNT_EN
            total++; if (ssc0 !== m_stall) begin bad++; $display("FAIL rnd_stall c=%0d got=%0d want=%0d", c, ssc0, m_stall); end
`endif
            for (int d = 0; d < 2; d++) begin
                pr[d] = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < NF; i++) begin
                    if (!pv[d][i] || m_acc[d*NF+i]) begin
                        pv[d][i] = ($urandom_range(0, 2) != 0);
                        pd[d][i*W +: W] = 8'($urandom);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midop;
        rst_n = 1'b0;
        pv[0] = '0; pv[1] = '0; pr[0] = 1'b0; pr[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pv[0] = 3'b011; pd[0] = {8'h00, 8'h91, 8'h81};
        @(negedge clk);
        pv[0] = 3'b001; pd[0] = {8'h00, 8'h00, 8'h82};
        @(negedge clk);
        pv[0] = '0;
        total++; if (occ0 !== 6'b00_01_10) begin bad++; $display("FAIL midop_occ got=%b want=000110", occ0); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (prdy0 !== 3'b000 || popv0 !== 1'b0 || occ0 !== '0) begin
            bad++; $display("FAIL midop_async got=%b/%b/%b want=000/0/0", prdy0, popv0, occ0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pr[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (popv0 !== 1'b0 || occ0 !== '0) begin
                bad++; $display("FAIL midop_stale k=%0d got=%b/%b want=0/0", k, popv0, occ0);
            end
`ifdef BR_FLOW_JOIN_SKEW_STALL_CNT_EN
            total++; if (ssc0 !== 32'd0) begin bad++; $display("FAIL midop_stall k=%0d got=%0d want=0", k, ssc0); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_skew();
        test_backpressure();
        test_depth1();
        test_random();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/br_flow_join_buffered.md
Name: br_flow_join_buffered

Overview:
- Registered, buffered successor to the combinational flow join.
- Joins NumFlows upstream ready-valid flows, each carrying Width bits, into one downstream flow carrying the concatenated data.
- Each push flow has its own Depth-entry FIFO, so upstream flows may arrive skewed by up to Depth transfers.
- push_ready has no combinational dependence on other flows' valids or on pop_ready. Sits at convergence points where independently timed producers must be aligned.

Parameters:
- NumFlows, 2, number of push flows; must be >= 2.
- Width, 8, data bits per push flow; must be >= 1.
- Depth, 2, entries per flow FIFO; must be >= 1; any value, not only powers of two; >= 2 required for full throughput.
- EnableAssertPushValidStability, 1, if 1 assert push_valid/push_data stable while backpressured.
- EnableAssertFinalNotValid, 1, if 1 assert no push_valid or pop_valid asserted at end of test.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- push_ready  output  NumFlows  per-flow ready.
- push_valid  input  NumFlows  per-flow valid.
- push_data  input  NumFlows*Width  flow i data at [i*Width +: Width].
- pop_ready  input  1  downstream ready.
- pop_valid  output  1  joined valid.
- pop_data  output  NumFlows*Width  flow i head at [i*Width +: Width].
- occupancy  output  NumFlows*$clog2(Depth+1)  per-flow entry count; flow i at [i*CW +: CW], where CW = $clog2(Depth+1).

Behaviour:
- Reset: asynchronous assert, synchronous-safe deassert.
  - All counts, read pointers and write pointers cleared to 0.
  - While rst_n=0: push_ready=0, pop_valid=0, occupancy=0.
  - First cycle after deassert: push_ready = all ones.
  - Reset mid-operation discards all buffered entries; no pop is issued for them.
- Per-flow FIFO i:
  - push_ready[i] = (count[i] < Depth), computed from registered state only.
  - Write occurs at the clock edge where push_valid[i] & push_ready[i].
  - Pointers wrap from Depth-1 to 0.
- Join:
  - pop_valid = AND over i of (count[i] != 0), from registered state only.
  - pop_data = concatenation of all FIFO heads.
  - A pop (pop_valid & pop_ready) removes one entry from every FIFO at the same edge.
- Simultaneous events:
  - Push and pop on the same flow in the same cycle: count unchanged, both pointers advance.
  - Full FIFO with pop this cycle: push_ready is still 0 this cycle (no ready bypass). Depth=1 therefore gives at most one transfer every 2 cycles.
- Latency: a push accepted on all flows at edge t into empty FIFOs gives pop_valid=1 in the cycle after edge t (1 cycle).
- Throughput: 1 pop/cycle sustained when Depth >= 2 and all flows are pushing.
- Skew: flow i may run ahead by up to Depth accepted transfers. Beyond that it is backpressured; other flows are unaffected.
- Stability: while pop_valid & !pop_ready, pop_valid and pop_data hold.
- occupancy: reports count[i], registered. Range 0..Depth; never exceeds Depth (assert).
- Assertions: no push on a full FIFO; no pop on an empty FIFO; static parameter range checks.

Optional Feature:
- Macro: BR_FLOW_JOIN_SKEW_STALL_CNT_EN.
- With it, adds output port skew_stall_count (32 bits).
  - Increments once per cycle where pop_valid=0 and at least one FIFO is non-empty, i.e. the join is waiting on a lagging flow.
  - Saturates at all ones; clears on reset.
- Without it: the port and counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, NumFlows=3, Width=8, Depth=2:
  - During rst_n=0: push_ready=3'b000, pop_valid=0.
  - After deassert: push_ready=3'b111, occupancy all 0.
- Aligned streaming, pop_ready=1: all flows push 0x10..0x1F together every cycle → pop_valid goes high 1 cycle after the first push. pop_data flow i matches pushed values in order; 1 pop/cycle sustained.
- Skew: flow 0 pushes 0xA1, 0xA2 with flows 1–2 idle.
  - Flow 0: occupancy=2, push_ready[0]=0, pop_valid=0.
  - Flows 1–2 then push 0xB1/0xC1 → pop_data={0xC1,0xB1,0xA1}, then push_ready[0]=1 after the pop.
- Backpressure, pop_ready=0 for 5 cycles with all FIFOs full → pop_valid=1 and pop_data constant, push_ready=0. Releasing pop_ready drains Depth pops in order.
- Depth=1, continuous valid on all flows, pop_ready=1 → exactly one pop every 2 cycles; no lost or duplicated entries.
- Reset asserted with occupancy={2,1,0} → all outputs 0 immediately (asynchronously). After release, no stale pop occurs and skew_stall_count=0 (macro enabled).
